// File: rtl/anf_fl_tex_quad_addr_gen_if.sv
// Request/response bundle between the sampler front-end, the texture
// address generator and the texture cache request port.
interface anf_fl_tex_quad_addr_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int COORD_W = 16,
  parameter int TAG_W   = 4
);
  // request channel
  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;
  logic [63:0]        req_meta;
  logic               req_bilin;
  logic [TAG_W-1:0]   req_tag;
  // texel address channel
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_addr;
  logic [3:0]         out_x_texel;
  logic [3:0]         out_y_texel;
  logic [1:0]         out_idx;
  logic               out_last;
  logic               out_err;
  logic [TAG_W-1:0]   out_tag;

  // requester / address consumer side
  modport master (
    output req_valid, req_x, req_y, req_meta, req_bilin, req_tag, out_ready,
    input  req_ready, out_valid, out_addr, out_x_texel, out_y_texel,
           out_idx, out_last, out_err, out_tag
  );

  // address generator side
  modport slave (
    input  req_valid, req_x, req_y, req_meta, req_bilin, req_tag, out_ready,
    output req_ready, out_valid, out_addr, out_x_texel, out_y_texel,
           out_idx, out_last, out_err, out_tag
  );
endinterface

// File: rtl/anf_fl_tex_quad_addr_gen.sv
// Texture address generator: turns one sample request into 1 (point) or 4
// (bilinear quad) texel byte addresses, with repeat/clamp wrapping and
// linear / 16-bit / 4x4-block / 16x16-tile layouts. Output beats are fully
// registered; beat k+1 (or the next request's beat 0) is computed while
// beat k is presented.
module anf_fl_tex_quad_addr_gen #(
  parameter int ADDR_W  = 32,
  parameter int COORD_W = 16,
  parameter int TAG_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  anf_fl_tex_quad_addr_gen_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t             state_r;
  logic [4:0]         fmt_r;
  logic [3:0]         we_r, he_r;
  logic               clamp_r, bilin_r;
  logic [31:0]        base_r;
  logic [COORD_W-1:0] x_r, y_r;
  logic [TAG_W-1:0]   tag_r;
  logic [1:0]         k_r;

  logic               out_valid_r, out_last_r, out_err_r;
  logic [ADDR_W-1:0]  out_addr_r;
  logic [3:0]         out_x_r, out_y_r;
  logic [1:0]         out_idx_r;
  logic [TAG_W-1:0]   out_tag_r;

  logic fire_s, req_ready_s, accept_s, load_s;
  logic unused_meta_s;

  // Wrap one coordinate (plus optional +1 quad step) into [0, (1<<e)-1].
  // One extra bit keeps x+1 from rolling over before the clamp compare.
  function automatic logic [COORD_W-1:0] wrap_coord(
    input logic [COORD_W-1:0] c,
    input logic               step,
    input logic [3:0]         e,
    input logic               clamp
  );
    logic [COORD_W:0] ce, lim, res;
    ce  = {1'b0, c} + {{COORD_W{1'b0}}, step};
    lim = ({{COORD_W{1'b0}}, 1'b1} << e) - {{COORD_W{1'b0}}, 1'b1};
    if (clamp) begin
      res = (ce > lim) ? lim : ce;
    end else begin
      res = ce & lim;
    end
    return COORD_W'(res);
  endfunction

  assign fire_s      = out_valid_r & bus.out_ready;
  assign req_ready_s = rst_n & ((state_r == IDLE) | (fire_s & out_last_r));
  assign accept_s    = bus.req_valid & req_ready_s;
  // a new beat is loaded on a new request or on any non-final handshake
  assign load_s      = accept_s | (fire_s & ~out_last_r);
  assign unused_meta_s = ^bus.req_meta[31:14];

  assign bus.req_ready   = req_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_addr    = out_addr_r;
  assign bus.out_x_texel = out_x_r;
  assign bus.out_y_texel = out_y_r;
  assign bus.out_idx     = out_idx_r;
  assign bus.out_last    = out_last_r;
  assign bus.out_err     = out_err_r;
  assign bus.out_tag     = out_tag_r;

  logic [4:0]         src_fmt_s;
  logic [3:0]         src_we_s, src_he_s;
  logic               src_clamp_s, src_bilin_s;
  logic [31:0]        src_base_s;
  logic [COORD_W-1:0] src_x_s, src_y_s;
  logic [TAG_W-1:0]   src_tag_s;
  logic [1:0]         nk_s;

  // Select the request the next beat belongs to: incoming one on accept, else the latched one.
  always_comb begin
    if (accept_s) begin
      src_fmt_s   = bus.req_meta[4:0];
      src_he_s    = bus.req_meta[8:5];
      src_we_s    = bus.req_meta[12:9];
      src_clamp_s = bus.req_meta[13];
      src_base_s  = bus.req_meta[63:32];
      src_x_s     = bus.req_x;
      src_y_s     = bus.req_y;
      src_bilin_s = bus.req_bilin;
      src_tag_s   = bus.req_tag;
      nk_s        = 2'd0;
    end else begin
      src_fmt_s   = fmt_r;
      src_he_s    = he_r;
      src_we_s    = we_r;
      src_clamp_s = clamp_r;
      src_base_s  = base_r;
      src_x_s     = x_r;
      src_y_s     = y_r;
      src_bilin_s = bilin_r;
      src_tag_s   = tag_r;
      nk_s        = k_r + 2'd1;
    end
  end

  logic [COORD_W-1:0] wx_s, wy_s;
  logic [3:0]         we2_s, we4_s;
  logic [ADDR_W-1:0]  xa_s, ya_s, p_s, b_s, t_s, q_s, off_s, nb_addr_s;
  logic               nb_err_s, nb_last_s;
  logic [3:0]         nb_tx_s, nb_ty_s;

  // Compute address, texel position and flags of the next beat.
  always_comb begin
    wx_s  = wrap_coord(src_x_s, nk_s[0], src_we_s, src_clamp_s);
    wy_s  = wrap_coord(src_y_s, nk_s[1], src_he_s, src_clamp_s);
    we2_s = (src_we_s >= 4'd2) ? (src_we_s - 4'd2) : 4'd0;
    we4_s = (src_we_s >= 4'd4) ? (src_we_s - 4'd4) : 4'd0;
    xa_s  = ADDR_W'(wx_s);
    ya_s  = ADDR_W'(wy_s);
    p_s   = (ya_s << src_we_s) + xa_s;
    b_s   = ((ya_s >> 2'd2) << we2_s) + (xa_s >> 2'd2);
    t_s   = ((ya_s >> 3'd4) << we4_s) + (xa_s >> 3'd4);
    q_s   = (t_s << 4'd8) + ADDR_W'({wy_s[3:0], wx_s[3:0]});
    nb_err_s = 1'b0;
    casez (src_fmt_s)
      5'b00000:                   off_s = (p_s << 2'd1) + p_s;
      5'b00100:                   off_s = p_s << 2'd2;
      5'b???01:                   off_s = p_s << 2'd1;
      5'b00010, 5'b10010, 5'b10110: off_s = b_s << 3'd3;
      5'b00110:                   off_s = b_s << 3'd4;
      5'b00011:                   off_s = (q_s << 2'd1) + q_s;
      5'b00111:                   off_s = q_s << 2'd2;
      5'b01011, 5'b01111, 5'b10111: off_s = q_s << 2'd1;
      5'b10011:                   off_s = q_s;
      default: begin
        off_s    = {ADDR_W{1'b0}};
        nb_err_s = 1'b1;
      end
    endcase
    nb_addr_s = ADDR_W'(src_base_s) + off_s;
    if (src_fmt_s[1:0] == 2'b10) begin
      nb_tx_s = {2'b00, wx_s[1:0]};
      nb_ty_s = {2'b00, wy_s[1:0]};
    end else begin
      nb_tx_s = wx_s[3:0];
      nb_ty_s = wy_s[3:0];
    end
    nb_last_s = src_bilin_s ? (nk_s == 2'd3) : 1'b1;
  end

  // Control FSM plus registered request context and output beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      fmt_r       <= 5'd0;
      we_r        <= 4'd0;
      he_r        <= 4'd0;
      clamp_r     <= 1'b0;
      bilin_r     <= 1'b0;
      base_r      <= 32'd0;
      x_r         <= {COORD_W{1'b0}};
      y_r         <= {COORD_W{1'b0}};
      tag_r       <= {TAG_W{1'b0}};
      k_r         <= 2'd0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_err_r   <= 1'b0;
      out_addr_r  <= {ADDR_W{1'b0}};
      out_x_r     <= 4'd0;
      out_y_r     <= 4'd0;
      out_idx_r   <= 2'd0;
      out_tag_r   <= {TAG_W{1'b0}};
    end else begin
      if (load_s) begin
        fmt_r      <= src_fmt_s;
        we_r       <= src_we_s;
        he_r       <= src_he_s;
        clamp_r    <= src_clamp_s;
        bilin_r    <= src_bilin_s;
        base_r     <= src_base_s;
        x_r        <= src_x_s;
        y_r        <= src_y_s;
        tag_r      <= src_tag_s;
        k_r        <= nk_s;
        out_addr_r <= nb_addr_s;
        out_err_r  <= nb_err_s;
        out_x_r    <= nb_tx_s;
        out_y_r    <= nb_ty_s;
        out_idx_r  <= nk_s;
        out_last_r <= nb_last_s;
        out_tag_r  <= src_tag_s;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r     <= EMIT;
            out_valid_r <= 1'b1;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        EMIT: begin
          if (fire_s && out_last_r && !accept_s) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_anf_fl_tex_quad_addr_gen.sv
// Directed, table-driven bench for the texture quad address generator.
module tb_anf_fl_tex_quad_addr_gen;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  anf_fl_tex_quad_addr_gen_if #(.ADDR_W(32), .COORD_W(16), .TAG_W(4)) bus ();

  anf_fl_tex_quad_addr_gen #(.ADDR_W(32), .COORD_W(16), .TAG_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]       meta;
    logic [15:0]       x;
    logic [15:0]       y;
    logic              bilin;
    logic [3:0]        tag;
    logic              err;
    logic [0:3][31:0]  a;
    logic [0:3][3:0]   tx;
    logic [0:3][3:0]   ty;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [63:0] mk_meta(input logic [31:0] base, input logic wrap,
                                          input logic [3:0] we, input logic [3:0] he,
                                          input logic [4:0] fmt);
    return {base, 18'd0, wrap, we, he, fmt};
  endfunction

  function automatic vec_t mkv(input logic [63:0] m, input logic [15:0] x, input logic [15:0] y,
                               input logic b, input logic [3:0] t, input logic e,
                               input logic [0:3][31:0] a, input logic [0:3][3:0] tx,
                               input logic [0:3][3:0] ty);
    vec_t v;
    v.meta = m; v.x = x; v.y = y; v.bilin = b; v.tag = t; v.err = e;
    v.a = a; v.tx = tx; v.ty = ty;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present a request at a negedge, wait (bounded) for acceptance; returns just after the accepting edge.
  task automatic send_req(input vec_t v);
    int n;
    bus.req_meta  = v.meta;
    bus.req_x     = v.x;
    bus.req_y     = v.y;
    bus.req_bilin = v.bilin;
    bus.req_tag   = v.tag;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {63'd0, bus.req_ready}, 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic check_beat(input string nm, input vec_t v, input int j, input int n);
    chk($sformatf("%s_valid%0d", nm, j), {63'd0, bus.out_valid}, 64'd1);
    chk($sformatf("%s_addr%0d", nm, j), {32'd0, bus.out_addr}, {32'd0, v.a[j]});
    chk($sformatf("%s_idx%0d", nm, j), {62'd0, bus.out_idx}, 64'(j));
    chk($sformatf("%s_last%0d", nm, j), {63'd0, bus.out_last}, (j == n - 1) ? 64'd1 : 64'd0);
    chk($sformatf("%s_err%0d", nm, j), {63'd0, bus.out_err}, {63'd0, v.err});
    chk($sformatf("%s_tag%0d", nm, j), {60'd0, bus.out_tag}, {60'd0, v.tag});
    chk($sformatf("%s_tx%0d", nm, j), {60'd0, bus.out_x_texel}, {60'd0, v.tx[j]});
    chk($sformatf("%s_ty%0d", nm, j), {60'd0, bus.out_y_texel}, {60'd0, v.ty[j]});
  endtask

  task automatic run_vec(input int i);
    int n;
    n = vecs[i].bilin ? 4 : 1;
    send_req(vecs[i]);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      check_beat($sformatf("v%0d", i), vecs[i], j, n);
    end
    @(negedge clk);
    chk($sformatf("v%0d_drain", i), {63'd0, bus.out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mkv(mk_meta(32'h1000_0000, 1'b0, 4'd8, 4'd8, 5'b00100), 16'd3, 16'd2, 1'b0, 4'd1, 1'b0,
                   {32'h1000_080C, 32'd0, 32'd0, 32'd0}, {4'd3, 4'd0, 4'd0, 4'd0}, {4'd2, 4'd0, 4'd0, 4'd0});
    vecs[1]  = mkv(mk_meta(32'h0, 1'b0, 4'd4, 4'd4, 5'b00000), 16'd15, 16'd0, 1'b1, 4'd2, 1'b0,
                   {32'd45, 32'd0, 32'd93, 32'd48}, {4'd15, 4'd0, 4'd15, 4'd0}, {4'd0, 4'd0, 4'd1, 4'd1});
    vecs[2]  = mkv(mk_meta(32'h0, 1'b1, 4'd4, 4'd4, 5'b00000), 16'd15, 16'd0, 1'b1, 4'd3, 1'b0,
                   {32'd45, 32'd45, 32'd93, 32'd93}, {4'd15, 4'd15, 4'd15, 4'd15}, {4'd0, 4'd0, 4'd1, 4'd1});
    vecs[3]  = mkv(mk_meta(32'h0, 1'b1, 4'd4, 4'd4, 5'b00000), 16'd40, 16'd0, 1'b0, 4'd4, 1'b0,
                   {32'd45, 32'd0, 32'd0, 32'd0}, {4'd15, 4'd0, 4'd0, 4'd0}, {4'd0, 4'd0, 4'd0, 4'd0});
    vecs[4]  = mkv(mk_meta(32'h0, 1'b0, 4'd6, 4'd6, 5'b00110), 16'd9, 16'd5, 1'b0, 4'd5, 1'b0,
                   {32'h120, 32'd0, 32'd0, 32'd0}, {4'd1, 4'd0, 4'd0, 4'd0}, {4'd1, 4'd0, 4'd0, 4'd0});
    vecs[5]  = mkv(mk_meta(32'h0, 1'b0, 4'd6, 4'd6, 5'b10011), 16'd20, 16'd17, 1'b0, 4'd6, 1'b0,
                   {32'h514, 32'd0, 32'd0, 32'd0}, {4'd4, 4'd0, 4'd0, 4'd0}, {4'd1, 4'd0, 4'd0, 4'd0});
    vecs[6]  = mkv(mk_meta(32'hABCD_0000, 1'b0, 4'd4, 4'd4, 5'b11011), 16'd5, 16'd6, 1'b0, 4'd7, 1'b1,
                   {32'hABCD_0000, 32'd0, 32'd0, 32'd0}, {4'd5, 4'd0, 4'd0, 4'd0}, {4'd6, 4'd0, 4'd0, 4'd0});
    vecs[7]  = mkv(mk_meta(32'h100, 1'b0, 4'd5, 4'd5, 5'b00001), 16'd33, 16'd2, 1'b0, 4'd8, 1'b0,
                   {32'h182, 32'd0, 32'd0, 32'd0}, {4'd1, 4'd0, 4'd0, 4'd0}, {4'd2, 4'd0, 4'd0, 4'd0});
    vecs[8]  = mkv(mk_meta(32'h2000, 1'b0, 4'd5, 4'd5, 5'b10010), 16'd31, 16'd31, 1'b1, 4'd9, 1'b0,
                   {32'h21F8, 32'h21C0, 32'h2038, 32'h2000}, {4'd3, 4'd0, 4'd3, 4'd0}, {4'd3, 4'd3, 4'd0, 4'd0});
    vecs[9]  = mkv(mk_meta(32'hFFFF_FFF0, 1'b0, 4'd2, 4'd2, 5'b00111), 16'd1, 16'd0, 1'b0, 4'd10, 1'b0,
                   {32'hFFFF_FFF4, 32'd0, 32'd0, 32'd0}, {4'd1, 4'd0, 4'd0, 4'd0}, {4'd0, 4'd0, 4'd0, 4'd0});
    vecs[10] = mkv(mk_meta(32'h0, 1'b0, 4'd15, 4'd15, 5'b01011), 16'h7000, 16'h7000, 1'b0, 4'd11, 1'b0,
                   {32'h700E_0000, 32'd0, 32'd0, 32'd0}, {4'd0, 4'd0, 4'd0, 4'd0}, {4'd0, 4'd0, 4'd0, 4'd0});

    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_x = 16'd0;
    bus.req_y = 16'd0;
    bus.req_meta = 64'd0;
    bus.req_bilin = 1'b0;
    bus.req_tag = 4'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_ready", {63'd0, bus.req_ready}, 64'd0);
    chk("rst_addr", {32'd0, bus.out_addr}, 64'd0);
    chk("rst_last", {63'd0, bus.out_last}, 64'd0);
    chk("rst_err", {63'd0, bus.out_err}, 64'd0);
    chk("rst_idx", {62'd0, bus.out_idx}, 64'd0);
    chk("rst_tag", {60'd0, bus.out_tag}, 64'd0);
    chk("rst_texel", {56'd0, bus.out_x_texel, bus.out_y_texel}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, bus.req_ready}, 64'd1);

    for (int i = 0; i < 11; i++) begin
      run_vec(i);
    end

    // stall on quad beat 1 for three cycles
    send_req(vecs[1]);
    @(negedge clk);
    chk("stall_idx0", {62'd0, bus.out_idx}, 64'd0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("stall_idx1", {62'd0, bus.out_idx}, 64'd1);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("stall_hold_valid%0d", s), {63'd0, bus.out_valid}, 64'd1);
      chk($sformatf("stall_hold_addr%0d", s), {32'd0, bus.out_addr}, 64'd0);
      chk($sformatf("stall_hold_idx%0d", s), {62'd0, bus.out_idx}, 64'd1);
      chk($sformatf("stall_hold_tx%0d", s), {60'd0, bus.out_x_texel}, 64'd0);
      chk($sformatf("stall_req_ready%0d", s), {63'd0, bus.req_ready}, 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_addr2", {32'd0, bus.out_addr}, 64'd93);
    chk("stall_idx2", {62'd0, bus.out_idx}, 64'd2);
    @(negedge clk);
    chk("stall_addr3", {32'd0, bus.out_addr}, 64'd48);
    chk("stall_last3", {63'd0, bus.out_last}, 64'd1);
    @(negedge clk);
    chk("stall_drain", {63'd0, bus.out_valid}, 64'd0);

    // back-to-back requests: second accepted on the last beat of the first
    send_req(vecs[0]);
    @(negedge clk);
    chk("b2b_a_addr", {32'd0, bus.out_addr}, 64'h1000_080C);
    bus.req_meta  = vecs[4].meta;
    bus.req_x     = vecs[4].x;
    bus.req_y     = vecs[4].y;
    bus.req_bilin = vecs[4].bilin;
    bus.req_tag   = vecs[4].tag;
    bus.req_valid = 1'b1;
    chk("b2b_req_ready", {63'd0, bus.req_ready}, 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_b_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("b2b_b_addr", {32'd0, bus.out_addr}, 64'h120);
    chk("b2b_b_tag", {60'd0, bus.out_tag}, 64'd5);
    chk("b2b_b_idx", {62'd0, bus.out_idx}, 64'd0);
    @(negedge clk);
    chk("b2b_drain", {63'd0, bus.out_valid}, 64'd0);

    // reset in the middle of a quad
    send_req(vecs[2]);
    @(negedge clk);
    chk("rq_idx0", {62'd0, bus.out_idx}, 64'd0);
    @(negedge clk);
    chk("rq_idx1", {62'd0, bus.out_idx}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rq_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rq_ready_in_rst", {63'd0, bus.req_ready}, 64'd0);
    chk("rq_idx", {62'd0, bus.out_idx}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rq_ready_after", {63'd0, bus.req_ready}, 64'd1);
    chk("rq_valid_after", {63'd0, bus.out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
